rf_bypass_8x16: RTL
===================

// Module: rf_bypass_8x16
// PURPOSE
//   8-entry x 16-bit register file: one write port, two combinational read ports.
//   Writes are captured on the rising clock edge. Optional same-cycle write-to-read bypass.
//   Storage is the per-register enabled-load register. Feeds the execute stage operand muxes.
//   Consumes writeback data from the WB stage.
// PARAMETERS
//   WIDTH     16  data width of each register
//   NUM_REGS  8   number of registers (power of 2)
//   ADDR_W    3   register address width, log2(NUM_REGS)
//   BYPASS    1   1: a read of the register being written returns writeData; 0: returns stored value
// PORTS
//   clk        in   1       system clock, rising-edge
//   rst        in   1       asynchronous, active-low reset (0 = reset)
//   read1Reg   in   ADDR_W  read port 1 address
//   read2Reg   in   ADDR_W  read port 2 address
//   writeReg   in   ADDR_W  write address
//   writeData  in   WIDTH   write data
//   writeEn    in   1       write enable, sampled on rising clk edge
//   read1Data  out  WIDTH   read port 1 data (combinational)
//   read2Data  out  WIDTH   read port 2 data (combinational)
//   err        out  1       registered; flags a write to an out-of-range register
// BEHAVIOUR
//   Reset
//   - rst=0 clears all registers and err asynchronously; the clock is not required.
//   - While rst=0, read1Data=read2Data=0, bypass is disabled, and writes are ignored.
//   - Reset mid-write (rst falls in the same cycle as writeEn=1): the write is lost; the register reads 0.
//   - First edge after rst rises: a normal write is honoured.
//   Write
//   - On the rising edge with writeEn=1, reg[writeReg] <= writeData. Latency: 1 edge.
//   - writeEn=0: all registers hold.
//   - Exactly one register is loaded per edge; the load enable is a one-hot decode of writeReg gated by writeEn.
//   Read
//   - readNData = reg[readNReg], purely combinational, 0-cycle latency.
//   - Both ports may address the same register; both return identical data.
//   Bypass
//   - Applies when BYPASS=1, writeEn=1, rst=1 and readNReg==writeReg.
//   - readNData = writeData in the same cycle, before the edge.
//   - After the edge, the stored value equals writeData, so the output does not glitch across the edge.
//   - When BYPASS=0, the new value is visible only after the edge.
//   Register 0
//   - Ordinary storage, not hard-wired to zero; the ISA decoder handles any zero semantics.
//   err
//   - err <= writeEn & (writeReg >= NUM_REGS).
//   - Always 0 when NUM_REGS = 2**ADDR_W; the check exists for non-power-of-2 builds.
//   - Out-of-range writes do not modify any register.
//   Width rules
//   - No arithmetic; data passes bit-exact. Addresses are unsigned.
// STRUCTURE
//   Shared package
//   - RF_WIDTH=16, RF_NUM_REGS=8, RF_ADDR_W=3, shared with decode and forwarding logic.
//   Sub-module: rf_reg_word
//   - One WIDTH-bit register with async active-low clear and load enable.
//   - Built as hold-mux + dff per bit.
//   - Instantiated NUM_REGS times via generate.
//   Top level
//   - Write decoder, two NUM_REGS:1 read muxes, bypass compare/mux per port, err flop.
// TESTING
//   1. Reset: rst=0 with arbitrary inputs, then release.
//      -> all 8 registers read 0 on both ports; err=0.
//   2. Write/readback: write reg i <= 16'h1111*i for i=0..7 on consecutive edges, then sweep read1Reg/read2Reg.
//      -> each port returns 16'h1111*i; the unaddressed port is unchanged.
//   3. Bypass: reg3=16'hAAAA; drive writeEn=1, writeReg=3, writeData=16'h5A5A, read1Reg=3, read2Reg=3 before the edge.
//      -> BYPASS=1: both read 16'h5A5A pre-edge.
//      -> BYPASS=0: both read 16'hAAAA pre-edge and 16'h5A5A post-edge.
//   4. Hold: writeEn=0, writeReg=5, writeData=16'hFFFF for 4 edges.
//      -> reg5 keeps its prior value 16'h5555.
//   5. Async reset mid-op: rst falls between edges while writeEn=1, writeData=16'hBEEF, writeReg=2.
//      -> all outputs 0 immediately; after release, reg2 reads 0, not 16'hBEEF.
//   6. Dual-port same address plus simultaneous write elsewhere: read1Reg=read2Reg=4, write reg6 <= 16'h1234.
//      -> both ports show reg4 unchanged; reg6=16'h1234 after the edge.

Source files
------------

// File: rtl/rf_bypass_8x16_pkg.sv
// Shared register-file sizing used by the register file, decode and forwarding logic.
// Also holds the address range helper used by the write-side error check.
package rf_bypass_8x16_pkg;

    localparam int RF_WIDTH    = 16;
    localparam int RF_NUM_REGS = 8;
    localparam int RF_ADDR_W   = 3;

    function automatic logic rf_addr_in_range(input logic [31:0] addr, input int num_regs);
        return (addr < 32'(num_regs));
    endfunction

endpackage

// File: rtl/rf_bypass_8x16_if.sv
// Register-file access bundle: one write port, two read ports and the write error flag.
// The master drives addresses and write data; the slave (the register file) returns read data.
interface rf_bypass_8x16_if
    import rf_bypass_8x16_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int ADDR_W = RF_ADDR_W
);
    logic [ADDR_W-1:0] read1Reg;
    logic [ADDR_W-1:0] read2Reg;
    logic [ADDR_W-1:0] writeReg;
    logic [WIDTH-1:0]  writeData;
    logic              writeEn;
    logic [WIDTH-1:0]  read1Data;
    logic [WIDTH-1:0]  read2Data;
    logic              err;

    modport master (
        output read1Reg, read2Reg, writeReg, writeData, writeEn,
        input  read1Data, read2Data, err
    );

    modport slave (
        input  read1Reg, read2Reg, writeReg, writeData, writeEn,
        output read1Data, read2Data, err
    );
endinterface

// File: rtl/rf_reg_word.sv
// One register-file word: per bit a hold mux feeding a flop with asynchronous active-low clear.
module rf_reg_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic hold_mux_s;
        logic bit_r;

        // Select new data on load, otherwise recirculate the stored bit
        always_comb begin
            if (ld) begin
                hold_mux_s = d[b];
            end else begin
                hold_mux_s = bit_r;
            end
        end

        // Storage flop, cleared asynchronously
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bit_r <= 1'b0;
            end else begin
                bit_r <= hold_mux_s;
            end
        end

        assign q[b] = bit_r;
    end

endmodule

// File: rtl/rf_bypass_8x16.sv
// 8x16 register file with one write port, two combinational read ports and optional
// same-cycle write-to-read bypass. err flags writes to addresses beyond NUM_REGS.
module rf_bypass_8x16
    import rf_bypass_8x16_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    rf_bypass_8x16_if.slave     rf
);

    localparam bit BYP_EN = (BYPASS != 0);

    logic [NUM_REGS-1:0] load_s;
    logic [WIDTH-1:0]    word_s [NUM_REGS];
    logic [WIDTH-1:0]    rd1_s;
    logic [WIDTH-1:0]    rd2_s;
    logic                wr_in_range_s;
    logic                hit1_s;
    logic                hit2_s;
    logic                err_r;

    assign wr_in_range_s = rf_addr_in_range(32'(rf.writeReg), NUM_REGS);

    // One-hot write decode gated by the write enable
    always_comb begin
        load_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            load_s[i] = rf.writeEn & (rf.writeReg == ADDR_W'(i));
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_word
        rf_reg_word #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk   (clk),
            .rst_n (rst),
            .ld    (load_s[r]),
            .d     (rf.writeData),
            .q     (word_s[r])
        );
    end

    // AND-OR read muxes; an unmapped address reads as zero
    always_comb begin
        rd1_s = '0;
        rd2_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd1_s = rd1_s | ({WIDTH{rf.read1Reg == ADDR_W'(i)}} & word_s[i]);
            rd2_s = rd2_s | ({WIDTH{rf.read2Reg == ADDR_W'(i)}} & word_s[i]);
        end
    end

    // Bypass is suppressed in reset so the outputs follow the cleared storage
    always_comb begin
        hit1_s = BYP_EN & rf.writeEn & rst & wr_in_range_s & (rf.read1Reg == rf.writeReg);
        hit2_s = BYP_EN & rf.writeEn & rst & wr_in_range_s & (rf.read2Reg == rf.writeReg);
        if (hit1_s) begin
            rf.read1Data = rf.writeData;
        end else begin
            rf.read1Data = rd1_s;
        end
        if (hit2_s) begin
            rf.read2Data = rf.writeData;
        end else begin
            rf.read2Data = rd2_s;
        end
    end

    // Out-of-range write flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= rf.writeEn & ~wr_in_range_s;
        end
    end

    assign rf.err = err_r;

endmodule
